// File: rtl/t09_sound_sequencer_pkg.sv
// Shared types and default timing constants for the team_09 sound sequencer.
// Defaults assume a 12 MHz system clock.
package t09_sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NOTE1 = 2'd1,
    ST_GAP   = 2'd2,
    ST_NOTE2 = 2'd3
  } state_e;

  // Codes double as priority: a larger code wins.
  typedef enum logic [1:0] {
    SND_NONE = 2'd0,
    SND_MOVE = 2'd1,
    SND_GOOD = 2'd2,
    SND_BAD  = 2'd3
  } sound_e;

  localparam logic [23:0] DEF_NOTE_LEN  = 24'd1_200_000;
  localparam logic [23:0] DEF_CLICK_LEN = 24'd120_000;
  localparam logic [23:0] DEF_GAP_LEN   = 24'd240_000;
  localparam logic [15:0] DEF_HP_GOOD   = 16'd6818;
  localparam logic [15:0] DEF_HP_BAD1   = 16'd13636;
  localparam logic [15:0] DEF_HP_BAD2   = 16'd27272;
  localparam logic [15:0] DEF_HP_MOVE   = 16'd3409;

  function automatic logic [1:0] pick_event(input logic bad, input logic good,
                                            input logic [3:0] dir);
    if (bad) return SND_BAD;
    if (good) return SND_GOOD;
    if (|dir) return SND_MOVE;
    return SND_NONE;
  endfunction

endpackage

// File: rtl/t09_sound_sequencer_if.sv
// Event/status bundle between the game logic and the sound sequencer.
interface t09_sound_sequencer_if;

  logic       enable;
  logic       badColl;
  logic       goodColl;
  logic [3:0] direction;
  logic       speaker;
  logic       busy;
  logic [1:0] sound_id;

  modport master (
    output enable, badColl, goodColl, direction,
    input  speaker, busy, sound_id
  );

  modport slave (
    input  enable, badColl, goodColl, direction,
    output speaker, busy, sound_id
  );

endinterface

// File: rtl/t09_sound_sequencer_tone_gen.sv
// Square-wave generator: toggles the speaker every half_period cycles while run is high.
// restart zeroes the phase so every note starts low with a full first half-period.
module t09_tone_gen (
  input  logic        clk,
  input  logic        nRst,
  input  logic        run,
  input  logic        restart,
  input  logic [15:0] half_period,
  output logic        speaker
);

  logic [15:0] cnt_q, cnt_d;
  logic        spk_q, spk_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    spk_d = spk_q;
    if (!run || restart) begin
      cnt_d = 16'd0;
      spk_d = 1'b0;
    end else if (cnt_q == half_period - 16'd1) begin
      cnt_d = 16'd0;
      spk_d = ~spk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      cnt_q <= 16'd0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  assign speaker = spk_q;

endmodule

// File: rtl/t09_sound_sequencer.sv
// Priority tone scheduler: picks BAD > GOOD > MOVE and plays a timed note pattern.
// Holds the FSM, the duration counter and the event acceptance rules.
module t09_sound_sequencer
  import t09_sound_pkg::*;
#(
  parameter logic [23:0] NOTE_LEN  = DEF_NOTE_LEN,
  parameter logic [23:0] CLICK_LEN = DEF_CLICK_LEN,
  parameter logic [23:0] GAP_LEN   = DEF_GAP_LEN,
  parameter logic [15:0] HP_GOOD   = DEF_HP_GOOD,
  parameter logic [15:0] HP_BAD1   = DEF_HP_BAD1,
  parameter logic [15:0] HP_BAD2   = DEF_HP_BAD2,
  parameter logic [15:0] HP_MOVE   = DEF_HP_MOVE
) (
  input logic             clk,
  input logic             nRst,
  t09_sound_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_NOTE1 = ST_NOTE1;
  localparam logic [1:0] S_GAP   = ST_GAP;
  localparam logic [1:0] S_NOTE2 = ST_NOTE2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  sid_q, sid_d;
  logic [23:0] dur_q, dur_d;
  logic        en_q;

  logic [1:0]  evt;
  logic [23:0] curLen;
  logic        durDone;
  logic        accept;
  logic        toneRun;
  logic        toneRestart;
  logic [15:0] halfPeriod;
  logic        speakerW;

  always_comb begin
    evt = pick_event(bus.badColl, bus.goodColl, bus.direction);

    case (state_q)
      S_NOTE1: curLen = (sid_q == SND_MOVE) ? CLICK_LEN : NOTE_LEN;
      S_GAP:   curLen = GAP_LEN;
      default: curLen = NOTE_LEN;
    endcase
    durDone = (dur_q == curLen - 24'd1);

    state_d = state_q;
    sid_d   = sid_q;
    dur_d   = dur_q + 24'd1;

    case (state_q)
      S_IDLE: begin
        sid_d = SND_NONE;
        dur_d = 24'd0;
      end
      S_NOTE1: begin
        if (durDone) begin
          dur_d = 24'd0;
          if (sid_q == SND_BAD) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            sid_d   = SND_NONE;
          end
        end
      end
      S_GAP: begin
        if (durDone) begin
          state_d = S_NOTE2;
          dur_d   = 24'd0;
        end
      end
      default: begin
        if (durDone) begin
          state_d = S_IDLE;
          sid_d   = SND_NONE;
          dur_d   = 24'd0;
        end
      end
    endcase

    // A sound about to end behaves like IDLE, so the next event chains without a gap.
    // en_q blocks events on the cycle enable first rises.
    accept = bus.enable && en_q && (evt != SND_NONE) &&
             ((state_d == S_IDLE) || (evt >= sid_q));

    if (accept) begin
      state_d = S_NOTE1;
      sid_d   = evt;
      dur_d   = 24'd0;
    end

    if (!bus.enable) begin
      state_d = S_IDLE;
      sid_d   = SND_NONE;
      dur_d   = 24'd0;
    end

    toneRun     = (state_d == S_NOTE1) || (state_d == S_NOTE2);
    toneRestart = accept || (state_d != state_q);

    if (state_d == S_NOTE2) begin
      halfPeriod = HP_BAD2;
    end else begin
      case (sid_d)
        SND_MOVE: halfPeriod = HP_MOVE;
        SND_BAD:  halfPeriod = HP_BAD1;
        default:  halfPeriod = HP_GOOD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      sid_q   <= SND_NONE;
      dur_q   <= 24'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sid_q   <= sid_d;
      dur_q   <= dur_d;
      en_q    <= bus.enable;
    end
  end

  t09_tone_gen u_tone (
    .clk         (clk),
    .nRst        (nRst),
    .run         (toneRun),
    .restart     (toneRestart),
    .half_period (halfPeriod),
    .speaker     (speakerW)
  );

  assign bus.speaker  = speakerW;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.sound_id = sid_q;

endmodule

// File: doc/t09_sound_sequencer.md
# t09_sound_sequencer

Priority-based tone scheduler for the team_09 game audio path. It takes game sound events (bad collision, good collision, direction change), picks one by fixed priority, and sequences a timed note pattern that drives the speaker pin as a square wave. It sits between the sound-mode FSM (`mode_o` feeds `enable`) and the top-level speaker output. It replaces the bare one-cycle `playSound` pulse with audible, fixed-length sounds.

## Interface
- `NOTE_LEN`, 1_200_000: cycles per note for GOOD and BAD notes (100 ms at 12 MHz); 24-bit.
- `CLICK_LEN`, 120_000: cycles for the MOVE click; 24-bit.
- `GAP_LEN`, 240_000: silent cycles between the two BAD notes; 24-bit.
- `HP_GOOD`, 6818: half-period in cycles, GOOD tone (880 Hz); 16-bit.
- `HP_BAD1`, 13636: half-period, first BAD note (440 Hz); 16-bit.
- `HP_BAD2`, 27272: half-period, second BAD note (220 Hz); 16-bit.
- `HP_MOVE`, 3409: half-period, MOVE click (1760 Hz); 16-bit.
- `clk` in 1: system clock.
- `nRst` in 1: reset, synchronous, active-low.
- `enable` in 1: sound on; driven by sound-mode FSM `mode_o`.
- `badColl` in 1: bad collision event, level sampled each cycle.
- `goodColl` in 1: good collision event.
- `direction` in 4: direction inputs; any nonzero bit is a MOVE event.
- `speaker` out 1: square-wave audio output.
- `busy` out 1: a sound is in progress (any state other than IDLE).
- `sound_id` out 2: current sound. 0 = none, 1 = MOVE, 2 = GOOD, 3 = BAD.

## Operation
- States: IDLE, NOTE1, GAP, NOTE2.
- Priority is BAD > GOOD > MOVE. When several events are asserted in the same cycle, only the highest is taken.
- Event acceptance:
  - In IDLE, any event is accepted.
  - While busy, an event with priority ≥ `sound_id` restarts that sound from NOTE1.
  - While busy, a lower-priority event is dropped and not queued.
- BAD: NOTE1 at `HP_BAD1` for `NOTE_LEN`, then GAP for `GAP_LEN`, then NOTE2 at `HP_BAD2` for `NOTE_LEN`, then IDLE.
- GOOD: NOTE1 at `HP_GOOD` for `NOTE_LEN`, then IDLE.
- MOVE: NOTE1 at `HP_MOVE` for `CLICK_LEN`, then IDLE.
- Duration counter (24-bit):
  - Clears on entry to each timed state.
  - Increments each cycle.
  - At `LEN-1` the state advances.
- Tone counter (16-bit):
  - Clears on note entry; `speaker` is forced 0 on note entry.
  - Counts 0..HP-1; at HP-1 it toggles `speaker` and wraps to 0.
- `speaker` is held 0 in IDLE and GAP.
- `enable` low:
  - Next edge forces IDLE, `speaker` 0, `sound_id` 0.
  - All events are ignored while `enable` is low, including events in the same cycle `enable` rises.
- Events are level-sampled. An input held high re-triggers on every cycle, so upstream must present one-cycle pulses.

## Timing
- Reset (`nRst` low at an edge): state IDLE, `speaker` 0, `busy` 0, `sound_id` 0, both counters 0. This applies mid-sound too.
- Latency: event sampled high at edge N gives `busy`=1 and the new `sound_id` after edge N; first `speaker` toggle after edge N+HP.
- Single GOOD sound occupies exactly `NOTE_LEN` cycles with `busy`=1.
- Single BAD sound occupies `2*NOTE_LEN+GAP_LEN` cycles.
- Single MOVE sound occupies `CLICK_LEN` cycles.
- Restart: the counters clear on the edge that accepts the event; no idle cycle is inserted.
- On the last cycle of a sound, a new event is accepted directly and IDLE is skipped.
- HP=1 gives a toggle on every cycle. HP and LEN values of 0 are illegal.

## Structure
- Package `t09_sound_pkg` holds:
  - the state enum;
  - the `sound_id` codes (NONE/MOVE/GOOD/BAD);
  - default half-period and length constants.
- Sub-module `t09_tone_gen` contains the 16-bit half-period counter and speaker toggle.
  - Inputs: `clk`, `nRst`, `run`, `restart`, `half_period`.
  - Output: `speaker`.
- The FSM, priority select and duration counter live in `t09_sound_sequencer`.

## Test plan
Bench parameters: `NOTE_LEN`=20, `GAP_LEN`=4, `CLICK_LEN`=6, `HP_GOOD`=2, `HP_BAD1`=3, `HP_BAD2`=5, `HP_MOVE`=1.

- One-cycle `goodColl` pulse → `busy` high for 20 cycles; `sound_id`=2; `speaker` toggles every 2 cycles, giving 10 toggles; then `speaker`=0, `busy`=0.
- `badColl` pulse → 20 cycles toggling every 3, then 4 silent cycles, then 20 cycles toggling every 5; total `busy` 44 cycles; `sound_id`=3 throughout.
- `direction`=4'b0010 and `goodColl` in the same cycle → `sound_id`=2. `direction` pulse at cycle 5 of GOOD → ignored, GOOD ends at cycle 20.
- `goodColl` at cycle 3 of MOVE → restart as GOOD: `sound_id`=2, counters cleared, `busy` lasts 20 more cycles.
- `enable` dropped at cycle 10 of BAD → next edge gives IDLE, `speaker` 0, `sound_id` 0. `badColl` while `enable` is low → no response.
- `nRst` low for one cycle mid-NOTE2 → all outputs 0 after that edge; the sound does not resume.
